// File: rtl/fod_controller.sv
// Fractional output divider controller: splits the accumulated FCW into MMD ratio,
// half-period retime select and DTC fine code, with sign-sign LMS DTC gain calibration.
module fod_controller #(
  parameter int WI        = 6,
  parameter int WF        = 16,
  parameter int KDTC_INIT = 512,
  parameter int CAL_EN    = 1
) (
  input  logic             CLK,
  input  logic             NARST,
  input  logic             DSM_EN,
  input  logic [WI+WF-1:0] FCW_FOD,
  input  logic [2:0]       PHE,
  output logic [5:0]       MMD_DCW,
  output logic             RT_DCW,
  output logic [9:0]       DTC_DCW
);

  localparam int SW = WI + WF + 1;  // sum width, one guard bit for MMD saturation
  localparam int RW = WF - 1;       // residual within half a VCO period
  localparam int KW = 10;           // DTC gain / code width
  localparam int PW = RW + KW + 1;  // product plus DSM residue
  localparam int AW = WF + 1;       // phase accumulator spans two VCO periods

  logic [SW-1:0] s;
  logic [WF-1:0] f_q;
  logic [RW-1:0] r;
  logic [RW-1:0] e_q, e_nxt;
  logic [PW-1:0] p;
  logic          dtc_sat;
  logic [KW-1:0] dtc_nxt;
  logic [5:0]    mmd_nxt;
  logic [KW-1:0] kdtc_q, kdtc_nxt;
  logic [AW-1:0] a_q, a_nxt;
  logic [2:0]    aexp_q;
  logic [2:0]    err;
  logic          r14_q;

  always_comb begin
    s       = SW'(f_q) + SW'(FCW_FOD);
    mmd_nxt = s[SW-1] ? '1 : s[WF +: 6];
    r       = s[RW-1:0];
    p       = PW'(r) * PW'(kdtc_q) + (DSM_EN ? PW'(e_q) : '0);
    dtc_sat = p[PW-1];
    dtc_nxt = dtc_sat ? '1 : p[RW +: KW];
    e_nxt   = (DSM_EN && !dtc_sat) ? p[RW-1:0] : '0;
    a_nxt   = a_q + FCW_FOD[AW-1:0];
  end

  // PHE observed now belongs to the edge predicted by the registered AEXP/R[14].
  always_comb begin
    kdtc_nxt = kdtc_q;
    err      = PHE - aexp_q;
    if ((CAL_EN != 0) && r14_q && (err != 3'd0)) begin
      if (err[2]) begin
        if (kdtc_q != '1) kdtc_nxt = kdtc_q + 1'b1;
      end else begin
        if (kdtc_q != '0) kdtc_nxt = kdtc_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      MMD_DCW <= 6'd4;
      RT_DCW  <= 1'b0;
      DTC_DCW <= '0;
      f_q     <= '0;
      a_q     <= '0;
      e_q     <= '0;
      kdtc_q  <= KW'(KDTC_INIT);
      aexp_q  <= '0;
      r14_q   <= 1'b0;
    end else begin
      MMD_DCW <= mmd_nxt;
      RT_DCW  <= s[WF-1];
      DTC_DCW <= dtc_nxt;
      f_q     <= s[WF-1:0];
      a_q     <= a_nxt;
      e_q     <= e_nxt;
      kdtc_q  <= kdtc_nxt;
      aexp_q  <= a_nxt[AW-1 -: 3];
      r14_q   <= r[RW-1];
    end
  end

endmodule

// File: tb/tb_fod_controller.sv
// Directed bench for fod_controller: constant traces plus a reference model feeding a
// scoreboard queue; one uncalibrated and one calibrating instance share the stimulus.
module tb_fod_controller;

  logic        clk = 1'b0;
  logic        narst;
  logic        dsm_en;
  logic [21:0] fcw;
  logic [2:0]  phe;
  logic [5:0]  mmd0, mmd1;
  logic        rt0, rt1;
  logic [9:0]  dtc0, dtc1;

  always #5 clk = ~clk;

  fod_controller #(.WI(6), .WF(16), .KDTC_INIT(512), .CAL_EN(0)) dut (
    .CLK(clk), .NARST(narst), .DSM_EN(dsm_en), .FCW_FOD(fcw), .PHE(phe),
    .MMD_DCW(mmd0), .RT_DCW(rt0), .DTC_DCW(dtc0));

  fod_controller #(.WI(6), .WF(16), .KDTC_INIT(512), .CAL_EN(1)) dut_cal (
    .CLK(clk), .NARST(narst), .DSM_EN(dsm_en), .FCW_FOD(fcw), .PHE(phe),
    .MMD_DCW(mmd1), .RT_DCW(rt1), .DTC_DCW(dtc1));

  typedef struct {
    string tag;
    int    mmd;
    int    rt;
    int    dtc;
    bit    sel;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   last_dtc;

  // reference model state
  int  m_f, m_a, m_e, m_k, m_aexp, m_r14, m_r;
  int  x_mmd, x_rt, x_dtc;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_f = 0; m_a = 0; m_e = 0; m_k = 512; m_aexp = 0; m_r14 = 0; m_r = 0;
  endtask

  task automatic model_edge(input int f_in, input bit dsm, input int phe_in, input bit cal);
    int s, p, err;
    s     = m_f + f_in;
    x_mmd = ((s >> 16) > 63) ? 63 : (s >> 16);
    x_rt  = (s >> 15) & 1;
    m_r   = s & 32'h7FFF;
    p     = m_r * m_k + (dsm ? m_e : 0);
    x_dtc = ((p >> 15) > 1023) ? 1023 : (p >> 15);
    m_e   = (dsm && ((p >> 15) <= 1023)) ? (p & 32'h7FFF) : 0;
    m_f   = s & 32'hFFFF;
    if (cal && m_r14 == 1) begin
      err = (phe_in - m_aexp) & 7;
      if (err >= 4 && m_k < 1023) m_k++;
      else if (err != 0 && err < 4 && m_k > 0) m_k--;
    end
    m_r14  = (m_r >> 14) & 1;
    m_a    = (m_a + f_in) & 32'h1FFFF;
    m_aexp = m_a >> 14;
  endtask

  // advance one CLK edge and compare against the oldest scoreboard entry
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = q.pop_front();
      if (e.sel) begin
        chk({e.tag, "_mmd"}, int'(mmd1), e.mmd);
        chk({e.tag, "_rt"},  int'(rt1),  e.rt);
        chk({e.tag, "_dtc"}, int'(dtc1), e.dtc);
        last_dtc = int'(dtc1);
      end else begin
        chk({e.tag, "_mmd"}, int'(mmd0), e.mmd);
        chk({e.tag, "_rt"},  int'(rt0),  e.rt);
        chk({e.tag, "_dtc"}, int'(dtc0), e.dtc);
        last_dtc = int'(dtc0);
      end
    end
  endtask

  task automatic const_step(input string tag, input int f_in, input bit dsm,
                            input int e_mmd, input int e_rt, input int e_dtc);
    exp_t e;
    fcw = f_in[21:0]; dsm_en = dsm; phe = 3'd0;
    model_edge(f_in, dsm, 0, 1'b0);
    e.tag = tag; e.mmd = e_mmd; e.rt = e_rt; e.dtc = e_dtc; e.sel = 1'b0;
    q.push_back(e);
    tick_check();
  endtask

  task automatic model_step(input string tag, input int f_in, input bit dsm,
                            input int phe_off, input bit sel);
    exp_t e;
    int   p_in;
    p_in = (m_aexp + phe_off) & 7;
    fcw = f_in[21:0]; dsm_en = dsm; phe = p_in[2:0];
    model_edge(f_in, dsm, p_in, sel);
    e.tag = tag; e.mmd = x_mmd; e.rt = x_rt; e.dtc = x_dtc; e.sel = sel;
    q.push_back(e);
    tick_check();
  endtask

  // called just after a checked edge: reset lands between edges, released before the next
  task automatic do_reset(input string tag);
    #2 narst = 1'b0;
    #1;
    chk({tag, "_mmd"}, int'(mmd0), 4);
    chk({tag, "_rt"},  int'(rt0),  0);
    chk({tag, "_dtc"}, int'(dtc0), 0);
    chk({tag, "_cal_mmd"}, int'(mmd1), 4);
    #1 narst = 1'b1;
    model_reset();
  endtask

  initial begin
    real sum_obs, sum_ideal, diff;
    narst = 1'b0; dsm_en = 1'b0; fcw = '0; phe = '0;
    model_reset();
    #6;
    do_reset("reset");

    // divide by 4.23, DSM off
    const_step("t423_e1", 32'h43AE1, 0, 4, 0, 235);
    const_step("t423_e2", 32'h43AE1, 0, 4, 0, 471);
    const_step("t423_e3", 32'h43AE1, 0, 4, 1, 194);
    const_step("t423_e4", 32'h43AE1, 0, 4, 1, 430);
    const_step("t423_e5", 32'h43AE1, 0, 5, 0, 153);
    const_step("t423_e6", 32'h43AE1, 0, 4, 0, 389);

    // integer ratio, then async reset mid-run and restart of the 4.23 trace
    do_reset("rst_int");
    for (int i = 0; i < 4; i++) const_step("int5", 32'h50000, 0, 5, 0, 0);
    do_reset("rst_mid");
    const_step("post_rst_e1", 32'h43AE1, 0, 4, 0, 235);
    const_step("post_rst_e2", 32'h43AE1, 0, 4, 0, 471);

    // half-integer ratio
    do_reset("rst_half");
    for (int i = 0; i < 3; i++) begin
      const_step("half_a", 32'h48000, 0, 4, 1, 0);
      const_step("half_b", 32'h48000, 0, 5, 0, 0);
    end

    // MMD saturation at the top of the FCW range
    do_reset("rst_sat");
    const_step("sat_e1", 32'h3FFFFF, 0, 63, 1, 511);
    const_step("sat_e2", 32'h3FFFFF, 0, 63, 1, 511);

    // DSM on: first edges fixed, long run against the ideal mean
    do_reset("rst_dsm");
    const_step("dsm_e1", 32'h43AE1, 1, 4, 0, 235);
    const_step("dsm_e2", 32'h43AE1, 1, 4, 0, 471);
    sum_obs = 0.0; sum_ideal = 0.0;
    for (int i = 0; i < 4096; i++) begin
      model_step("dsm_run", 32'h43AE1, 1, 0, 1'b0);
      sum_obs   += real'(last_dtc);
      sum_ideal += real'(m_r) * 512.0 / 32768.0;
    end
    diff = (sum_obs - sum_ideal) / 4096.0;
    if (diff < 0.0) diff = -diff;
    chk("dsm_mean_within_0p01", int'(diff <= 0.01), 1);

    // DSM toggled off mid-run without clearing F
    model_step("dsm_off", 32'h43AE1, 0, 0, 1'b0);
    model_step("dsm_off", 32'h43AE1, 0, 0, 1'b0);

    // calibration: late edges drive KDTC down to 0, then early edges up to 1023
    do_reset("rst_cal");
    for (int i = 0; i < 560; i++) model_step("cal_down", 32'h47FFF, 0, 1, 1'b1);
    chk("cal_floor_dtc", last_dtc, 0);
    for (int i = 0; i < 1100; i++) model_step("cal_up", 32'h47FFF, 0, -1, 1'b1);
    chk("cal_ceiling_k", m_k, 1023);
    chk("cal_ceiling_dtc", last_dtc, (m_r * 1023) >> 15);
    for (int i = 0; i < 4; i++) model_step("cal_hold", 32'h47FFF, 0, 0, 1'b1);

    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fod_controller.md
Name: fod_controller

Overview:
- Digital controller for a fractional output divider (FOD); all state updates on each divided/DTC-delayed output edge (CLK).
- Accumulates the fractional frequency control word and drives three delay paths:
  - integer divide ratio to the multi-modulus divider,
  - half-VCO-period select to the pos/neg retimer,
  - 10-bit fine-delay code to the DTC.
- Runs a sign-sign LMS background calibration of the DTC gain, using the 3-bit phase error from the 8-phase auxiliary-PLL sampler array.

Parameters:
- WI, 6, integer bits of FCW_FOD.
- WF, 16, fractional bits of FCW_FOD.
- KDTC_INIT, 512, reset DTC gain: DTC codes per half VCO period.
- CAL_EN, 1, 1 enables DTC gain calibration; 0 holds KDTC at KDTC_INIT.

Ports:
- CLK  in  1  controller clock (FOD output edge from DTC); rising edge active.
- NARST  in  1  asynchronous active-low reset.
- DSM_EN  in  1  1 enables first-order noise shaping of DTC code truncation.
- FCW_FOD  in  WI+WF  unsigned divide ratio in VCO periods, U6.16.
- PHE  in  3  sampled phase of the FOD edge in the 2-VCO-period aux cycle, 1/8 aux-period steps.
- MMD_DCW  out  6  integer divide ratio for the next MMD cycle.
- RT_DCW  out  1  0 = retime on posedge, 1 = retime on negedge (+0.5 VCO period).
- DTC_DCW  out  10  DTC fine delay code.

Behaviour:
- Reset (NARST low, asynchronous):
  - Outputs: MMD_DCW=4, RT_DCW=0, DTC_DCW=0.
  - Internal state: F (16b fraction acc)=0, A (17b phase acc, 1 int + 16 frac)=0, E (15b DSM residue)=0, KDTC=KDTC_INIT, AEXP (3b)=0.
- Release of reset is synchronous to the first CLK edge after NARST rises.
- Each CLK posedge, all outputs registered, effective for the next output edge:
  - S = {F} + FCW_FOD, 23-bit.
  - MMD_DCW = S[21:16]; if S[22:16] > 63, saturate MMD_DCW to 63.
  - F <= S[15:0].
  - RT_DCW <= S[15].
  - R = S[14:0], residual within half period.
  - P = R*KDTC (25b) + (DSM_EN ? E : 0).
  - DTC_DCW <= min(P>>15, 1023).
  - E <= DSM_EN ? P[14:0] : 0. If saturated, E <= 0.
  - A <= (A + FCW_FOD) mod 2 VCO periods, i.e. 17-bit wrap.
  - AEXP <= A_new[16:14]: expected PHE for this edge.
- Calibration, when CAL_EN=1:
  - The PHE presented at CLK k belongs to the edge scheduled at k-1, so compare PHE with AEXP (the registered value) before it updates.
  - err = (PHE − AEXP) mod 8, interpreted signed −4..3.
  - Update only when the previous cycle's R[14]=1, i.e. large DTC usage.
  - err>0 (edge late): KDTC −1. err<0 (edge early): KDTC +1. err=0: hold.
  - KDTC clamps at 0 and 1023, no wrap.
- DSM_EN toggling mid-operation: takes effect on the next CLK; no reset of F or A.
- FCW_FOD changes are sampled every CLK; no glitch protection required.

Test Plan:
- Divide-by-4.23 trace: reset, FCW_FOD=0x43AE1 (4.23·2^16, truncated), DSM_EN=0, CAL_EN=0, PHE tied to 0. Required on CLK edges 1..5:
  - MMD_DCW = 4,4,4,4,5.
  - RT_DCW = 0,0,1,1,0.
  - DTC_DCW = 235,471,194,…; F after edge 5 = 9829.
- DSM on: same stimulus with DSM_EN=1 -> DTC_DCW edge1=235, edge2=471. The long-run average of DTC_DCW over 4096 edges matches the ideal R·KDTC/2^15 within 0.01 LSB.
- Integer FCW: FCW_FOD=0x50000 -> MMD_DCW=5, RT_DCW=0, DTC_DCW=0 every cycle; F stays 0.
- Half-integer FCW: FCW_FOD=0x48000 -> MMD_DCW alternates 4,5; RT_DCW alternates 1,0; DTC_DCW=0.
- Async reset mid-run: assert NARST between CLK edges -> outputs go to 4/0/0 immediately with no CLK; first post-release edge behaves as edge 1.
- Calibration: CAL_EN=1, FCW giving R[14]=1, PHE forced to AEXP+1 -> KDTC decrements 1 per qualifying edge down to 0 and stays there. PHE=AEXP−1 -> saturates at 1023.
